// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared constants for the round-robin mux arbiter slice.
//   STATE_IDLE / STATE_HOLD : output-register state encoding (y_valid == state)
//   DEF_N_REQ / DEF_DATA_W  : default requester count and data word width
//   GNT_ID_W                : width of the winner index (covers up to 8 requesters)
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int GNT_ID_W   = 3;

  // The encoding is chosen so that the state bit doubles as y_valid.
  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_HOLD = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Returns the first set bit of
// 'eligible' at or above 'ptr', wrapping from N_REQ-1 back to 0.
// Ports:
//   eligible  in  N_REQ     candidate request vector
//   ptr       in  3         index holding highest priority (0..N_REQ-1)
//   winner    out 3         selected index (0 when nothing is eligible)
//   any_valid out 1         at least one eligible bit was found
// ---------------------------------------------------------------------------
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]    eligible,
  input  logic [GNT_ID_W-1:0] ptr,
  output logic [GNT_ID_W-1:0] winner,
  output logic                any_valid
);

  // The wrap is done as two scans: first the indices at or above ptr, then
  // from 0 upward. The second scan only matters when the first found nothing,
  // and since every index below ptr comes before every index at or above it in
  // plain order, it naturally yields the wrapped winner.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_valid && eligible[i] && (i >= int'(ptr))) begin
        any_valid = 1'b1;
        winner    = GNT_ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_valid && eligible[i]) begin
        any_valid = 1'b1;
        winner    = GNT_ID_W'(i);
      end
    end
  end

endmodule : rr_pick

// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
// Round-robin arbiter that registers one requester's data word onto a shared
// output with a valid/ready handshake.
// Ports:
//   clk      in  1              rising-edge clock
//   rst_n    in  1              asynchronous active-low reset
//   req      in  N_REQ          level requests, bit i = requester i
//   din      in  N_REQ*DATA_W   data words, din[i*DATA_W +: DATA_W] = requester i
//   gnt      out N_REQ          one-cycle one-hot grant, registered
//   gnt_id   out 3              index of the requester whose word is on y
//   y        out DATA_W         registered output word
//   y_valid  out 1              y holds a word not yet accepted
//   y_ready  in  1              downstream accepts y when y_valid && y_ready
// ---------------------------------------------------------------------------
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   din,
  output logic [N_REQ-1:0]          gnt,
  output logic [GNT_ID_W-1:0]       gnt_id,
  output logic [DATA_W-1:0]         y,
  output logic                      y_valid,
  input  logic                      y_ready
);

  logic                state_q, state_d;
  logic [GNT_ID_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [GNT_ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [DATA_W-1:0]   y_q, y_d;

  logic [N_REQ-1:0]    eligible;
  logic [GNT_ID_W-1:0] winner;
  logic                any_valid;
  logic                load;
  logic [DATA_W-1:0]   win_word;

  // The requester granted last cycle is masked out so it cannot win twice in
  // a row just because its req is still high while it reacts to the grant.
  assign eligible = req & ~gnt_q;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // A new word may enter whenever the output register is empty or is being
  // drained on this very edge.
  assign load = ((state_q == STATE_IDLE) || y_ready) && any_valid;

  always_comb begin
    win_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == GNT_ID_W'(i)) begin
        win_word = din[i*DATA_W +: DATA_W];
      end
    end
  end

  // In HOLD without ready everything freezes; in HOLD with ready and nothing
  // to load the register empties but y keeps its stale value.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    y_d      = y_q;
    if (load) begin
      state_d  = STATE_HOLD;
      y_d      = win_word;
      gnt_id_d = winner;
      for (int i = 0; i < N_REQ; i++) begin
        gnt_d[i] = (winner == GNT_ID_W'(i));
      end
      if (winner == GNT_ID_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + GNT_ID_W'(1);
      end
    end else if ((state_q == STATE_HOLD) && y_ready) begin
      state_d = STATE_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STATE_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      y_q      <= y_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign y       = y_q;
  assign y_valid = (state_q == STATE_HOLD);

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_arbiter
// Directed bench for mux_arbiter (N_REQ=4, DATA_W=8). Inputs are driven and
// outputs sampled on the falling clock edge; expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [2:0]  gnt_id;
  logic [7:0]  y;
  logic        y_valid;
  logic        y_ready;

  int total = 0;
  int bad   = 0;

  mux_arbiter #(
    .N_REQ  (4),
    .DATA_W (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant must never carry more than one bit, and any grant must coincide
  // with a freshly loaded (valid) word.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert ($onehot0(gnt) && ((gnt == 4'b0000) || y_valid)) else begin
        bad++;
        $error("[TB] FAIL gnt_onehot got gnt=%b y_valid=%b want onehot0 and valid", gnt, y_valid);
      end
    end
  end

  // Places one requester's word into the packed din bus.
  task automatic setDin(input int idx, input logic [7:0] val);
    din[idx*8 +: 8] = val;
  endtask

  // Drives req/y_ready at a falling edge and advances to the next falling
  // edge, so exactly one rising edge sees the new values.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    req     = r;
    y_ready = rdy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_gnt,
                             input logic [2:0] e_id, input logic [7:0] e_y,
                             input logic e_valid);
    total++;
    assert (gnt === e_gnt) else begin
      bad++;
      $error("[TB] FAIL %s.gnt got %b want %b", tag, gnt, e_gnt);
    end
    total++;
    assert (gnt_id === e_id) else begin
      bad++;
      $error("[TB] FAIL %s.gnt_id got %0d want %0d", tag, gnt_id, e_id);
    end
    total++;
    assert (y === e_y) else begin
      bad++;
      $error("[TB] FAIL %s.y got %h want %h", tag, y, e_y);
    end
    total++;
    assert (y_valid === e_valid) else begin
      bad++;
      $error("[TB] FAIL %s.y_valid got %b want %b", tag, y_valid, e_valid);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    din     = '0;
    y_ready = 1'b0;
    @(negedge clk);

    // Reset state, including a request that must be ignored while reset is low
    $display("[TB] reset");
    applyStimulus(4'b0000, 1'b0);
    checkOutput("reset", 4'b0000, 3'd0, 8'h00, 1'b0);
    setDin(0, 8'hA5);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("reset_req", 4'b0000, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("release", 4'b0000, 3'd0, 8'h00, 1'b0);
    @(negedge clk);

    // Hmm: the release was mid-low-phase, so one rising edge has now passed
    // with rst_n=1 and req=0001 -> first load.
    $display("[TB] single request");
    checkOutput("single_load", 4'b0001, 3'd0, 8'hA5, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_drain", 4'b0000, 3'd0, 8'hA5, 1'b0);

    // Fresh reset so the pointer starts at 0 again
    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    rst_n = 1'b1;

    $display("[TB] round robin");
    setDin(0, 8'h11);
    setDin(1, 8'h22);
    setDin(2, 8'h33);
    setDin(3, 8'h44);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rr0", 4'b0001, 3'd0, 8'h11, 1'b1);
    applyStimulus(4'b1110, 1'b1);
    checkOutput("rr1", 4'b0010, 3'd1, 8'h22, 1'b1);
    applyStimulus(4'b1100, 1'b1);
    checkOutput("rr2", 4'b0100, 3'd2, 8'h33, 1'b1);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("rr3", 4'b1000, 3'd3, 8'h44, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rr_idle", 4'b0000, 3'd3, 8'h44, 1'b0);

    // Backpressure: pointer is 0 here
    $display("[TB] backpressure");
    setDin(0, 8'h5A);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("bp_load", 4'b0001, 3'd0, 8'h5A, 1'b1);
    for (int k = 0; k < 4; k++) begin
      din = {4{8'(8'hF0 + k)}};
      applyStimulus(4'b1110, 1'b0);
      checkOutput("bp_hold", 4'b0000, 3'd0, 8'h5A, 1'b1);
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("bp_drain", 4'b0000, 3'd0, 8'h5A, 1'b0);

    // Wrap: pointer is 1; granting 2 moves it to 3
    $display("[TB] wrap");
    setDin(0, 8'hD0);
    setDin(2, 8'hC2);
    setDin(3, 8'hD3);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("wrap_g2", 4'b0100, 3'd2, 8'hC2, 1'b1);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("wrap_g3", 4'b1000, 3'd3, 8'hD3, 1'b1);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("wrap_g0", 4'b0001, 3'd0, 8'hD0, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("wrap_idle", 4'b0000, 3'd0, 8'hD0, 1'b0);

    // Mid-operation asynchronous reset while holding 0x7E
    $display("[TB] mid reset");
    setDin(1, 8'h7E);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("mr_load", 4'b0010, 3'd1, 8'h7E, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("mr_hold", 4'b0000, 3'd1, 8'h7E, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_async", 4'b0000, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    setDin(2, 8'hC4);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("mr_after", 4'b0100, 3'd2, 8'hC4, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("mr_idle", 4'b0000, 3'd2, 8'hC4, 1'b0);

    // Continuous single request: granted on alternate cycles only
    $display("[TB] continuous");
    setDin(1, 8'hB1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0010, 1'b1);
      if (k % 2 == 0) begin
        checkOutput("cont_on", 4'b0010, 3'd1, 8'hB1, 1'b1);
      end else begin
        checkOutput("cont_off", 4'b0000, 3'd1, 8'hB1, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_arbiter
